// File: rtl/matmul_pkg.sv
// Types and width helpers shared across the scalar-product datapath.
package matmul_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    function automatic int prod_width(input int nbits);
        return 2 * nbits;
    endfunction

    function automatic int sum_width(input int nbits, input int ndata);
        return 2 * nbits + $clog2(ndata);
    endfunction

endpackage

// File: rtl/product_packer.sv
// Packs Ndata serial products into one wide vector behind a valid/ready handshake.
// Optional running element sum on out_sum when PRODUCT_PACKER_SUM_EN is defined.
module product_packer
    import matmul_pkg::*;
#(
    parameter int Nbits = 4,
    parameter int Ndata = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [prod_width(Nbits)-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [Ndata*prod_width(Nbits)-1:0] out_data
`ifdef PRODUCT_PACKER_SUM_EN
    ,
    output logic [sum_width(Nbits, Ndata)-1:0] out_sum
`endif
);

    localparam int PW = prod_width(Nbits);
    localparam int VW = Ndata * PW;
    localparam int CW = $clog2(Ndata);
    localparam logic [CW-1:0] CNT_LAST = CW'(Ndata - 1);

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [VW-1:0]   data_reg;
    logic            out_valid_reg;
    logic            accept;
    logic            release_ev;
    logic [VW-1:0]   data_next;

    // Only in_ready is combinational, and only while a vector waits for release.
    assign in_ready   = (state_reg == FILL) ? 1'b1 : out_ready;
    assign accept     = in_valid && in_ready;
    assign release_ev = out_valid_reg && out_ready;
    assign data_next  = {in_data, data_reg[VW-1:PW]};

    assign out_valid = out_valid_reg;
    assign out_data  = data_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= FILL;
            cnt_reg       <= '0;
            data_reg      <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (accept) begin
                        data_reg <= data_next;
                        if (cnt_reg == CNT_LAST) begin
                            cnt_reg       <= '0;
                            state_reg     <= FULL;
                            out_valid_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                end
                FULL: begin
                    // An element arriving in the release cycle opens the next vector.
                    if (release_ev) begin
                        state_reg     <= FILL;
                        out_valid_reg <= 1'b0;
                        if (accept) begin
                            data_reg <= data_next;
                            cnt_reg  <= CW'(1);
                        end else begin
                            cnt_reg  <= '0;
                        end
                    end
                end
                default: state_reg <= FILL;
            endcase
        end
    end

`ifdef PRODUCT_PACKER_SUM_EN
    localparam int SW = sum_width(Nbits, Ndata);
    logic [SW-1:0] sum_reg;
    logic          first_elem;

    // Element 0 of a vector is either a FILL accept at cnt 0 or the release-cycle accept.
    assign first_elem = (state_reg == FULL) || (cnt_reg == '0);
    assign out_sum    = sum_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_reg <= '0;
        end else if (accept) begin
            sum_reg <= first_elem ? SW'(in_data) : sum_reg + SW'(in_data);
        end
    end
`endif

endmodule

// File: tb/tb_product_packer.sv
// Randomized and directed checks of product_packer against a queue-based packing model.
module tb_product_packer;

    localparam int NB = 4;
    localparam int ND = 8;
    localparam int PW = 2 * NB;
    localparam int VW = ND * PW;
    localparam int SW = PW + $clog2(ND);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [VW-1:0] out_data;
`ifdef PRODUCT_PACKER_SUM_EN
    logic [SW-1:0] out_sum;
`endif

    int checks = 0;
    int failures = 0;

    // model state
    logic [PW-1:0] model_q[$];
    logic [VW-1:0] exp_vec = '0;
    int            exp_sum = 0;
    bit            exp_full = 1'b0;
    bit            acc, rel;

    product_packer #(.Nbits(NB), .Ndata(ND)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef PRODUCT_PACKER_SUM_EN
        ,
        .out_sum   (out_sum)
`endif
    );

    always #5 clk = ~clk;

    function automatic void model_accept(input logic [PW-1:0] d);
        model_q.push_back(d);
        if (model_q.size() == ND) begin
            exp_vec = '0;
            exp_sum = 0;
            for (int i = 0; i < ND; i++) begin
                exp_vec[i*PW +: PW] = model_q[i];
                exp_sum += int'(model_q[i]);
            end
            exp_full = 1'b1;
            model_q.delete();
        end
    endfunction

    // One clock: observe handshakes mid-cycle, update model at the edge, return 1 time unit after.
    task automatic tick();
        @(negedge clk);
        acc = in_valid && in_ready;
        rel = out_valid && out_ready;
        @(posedge clk);
        if (reset) begin
            model_q.delete();
            exp_full = 1'b0;
        end else begin
            if (rel) exp_full = 1'b0;
            if (acc) model_accept(in_data);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            failures++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b out_data=%h, required 0 1 0", out_valid, in_ready, out_data);
        end
`ifdef PRODUCT_PACKER_SUM_EN
        checks++;
        if (out_sum !== '0) begin
            failures++;
            $display("FAIL reset_sum: out_sum=%0d required 0", out_sum);
        end
`endif
    endtask

    task automatic test_basic_fill();
        logic [PW-1:0] prods[ND] = '{8'd0, 8'd6, 8'd10, 8'd12, 8'd12, 8'd10, 8'd6, 8'd0};
        out_ready = 1'b0;
        for (int i = 0; i < ND; i++) begin
            in_valid = 1'b1; in_data = prods[i];
            tick();
            if (i == ND - 2) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL fill_early_valid: out_valid=%b required 0", out_valid);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'h00060A0C0C0A0600 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_vector: out_valid=%b out_data=%h in_ready=%b, required 1 00060a0c0c0a0600 0", out_valid, out_data, in_ready);
        end
`ifdef PRODUCT_PACKER_SUM_EN
        checks++;
        if (out_sum !== 11'd56) begin
            failures++;
            $display("FAIL fill_sum: out_sum=%0d required 56", out_sum);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] held;
        held = exp_vec;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_data = PW'($urandom);
            tick();
            checks++;
            if (acc || out_valid !== 1'b1 || out_data !== held) begin
                failures++;
                $display("FAIL backpressure_hold: accepted=%b out_valid=%b out_data=%h, required 0 1 %h", acc, out_valid, out_data, held);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        checks++;
        if (!rel || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_release: released=%b out_valid=%b in_ready=%b, required 1 0 1", rel, out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 1; i <= 2 * ND; i++) begin
            in_valid = 1'b1; in_data = PW'(i);
            tick();
            checks++;
            if (!acc) begin
                failures++;
                $display("FAIL b2b_bubble: element %0d accepted=0 required 1", i);
            end
            if (i == ND || i == 2 * ND) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== (i == ND ? 64'h0807060504030201 : 64'h100F0E0D0C0B0A09)) begin
                    failures++;
                    $display("FAIL b2b_vector%0d: out_valid=%b out_data=%h", i / ND, out_valid, out_data);
                end
`ifdef PRODUCT_PACKER_SUM_EN
                checks++;
                if (out_sum !== (i == ND ? 11'd36 : 11'd100)) begin
                    failures++;
                    $display("FAIL b2b_sum%0d: out_sum=%0d required %0d", i / ND, out_sum, (i == ND ? 36 : 100));
                end
`endif
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_gapped();
        int n = 0;
        int cyc = 0;
        out_ready = 1'b0;
        while (n < ND && cyc < 200) begin
            in_valid = 1'($urandom_range(0, 1)); in_data = 8'hFF;
            tick();
            if (acc) n++;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (n != ND || out_valid !== 1'b1 || out_data !== {ND{8'hFF}}) begin
            failures++;
            $display("FAIL gapped_vector: accepts=%0d out_valid=%b out_data=%h, required 8 1 all ff", n, out_valid, out_data);
        end
`ifdef PRODUCT_PACKER_SUM_EN
        checks++;
        if (out_sum !== 11'd2040) begin
            failures++;
            $display("FAIL gapped_sum: out_sum=%0d required 2040", out_sum);
        end
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            in_data = PW'($urandom);
            tick();
            checks++;
            if (out_valid !== exp_full || in_ready !== (!exp_full || out_ready)
                || (exp_full && out_data !== exp_vec)) begin
                failures++;
                $display("FAIL random_cycle%0d: out_valid=%b in_ready=%b out_data=%h, required %b %b %h",
                         c, out_valid, in_ready, out_data, exp_full, (!exp_full || out_ready), exp_vec);
            end
`ifdef PRODUCT_PACKER_SUM_EN
            if (exp_full) begin
                checks++;
                if (int'(out_sum) != exp_sum) begin
                    failures++;
                    $display("FAIL random_sum%0d: out_sum=%0d required %0d", c, out_sum, exp_sum);
                end
            end
`endif
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = PW'($urandom);
            tick();
        end
        in_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
            failures++;
            $display("FAIL midfill_reset: out_valid=%b in_ready=%b out_data=%h, required 0 1 0", out_valid, in_ready, out_data);
        end
        for (int i = 0; i < ND; i++) begin
            in_valid = 1'b1; in_data = 8'd5;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== {ND{8'h05}}) begin
            failures++;
            $display("FAIL midfill_vector: out_valid=%b out_data=%h, required 1 all 05", out_valid, out_data);
        end
`ifdef PRODUCT_PACKER_SUM_EN
        checks++;
        if (out_sum !== 11'd40) begin
            failures++;
            $display("FAIL midfill_sum: out_sum=%0d required 40", out_sum);
        end
`endif
    endtask

    task automatic test_reset_full();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL full_reset: out_valid=%b out_data=%h in_ready=%b, required 0 0 1", out_valid, out_data, in_ready);
        end
`ifdef PRODUCT_PACKER_SUM_EN
        checks++;
        if (out_sum !== '0) begin
            failures++;
            $display("FAIL full_reset_sum: out_sum=%0d required 0", out_sum);
        end
`endif
    endtask

    initial begin
        #1;
        test_reset();
        test_basic_fill();
        test_backpressure();
        test_back_to_back();
        test_gapped();
        test_random();
        test_reset_mid_fill();
        test_reset_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
